// File: rtl/cdc_pulse_arbiter_if.sv
// Handshake bundle for cdc_pulse_arbiter: clka-side request/status signals and
// clkb-side delivered pulse and index.
interface cdc_pulse_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0] req_a;
  logic [N_REQ-1:0] pend_a;
  logic             busy_a;
  logic             ovf_a;
  logic             done_a;
  logic [N_REQ-1:0] pulse_b;
  logic [ID_W-1:0]  id_b;

  modport master (
    output req_a,
    input  pend_a, busy_a, ovf_a, done_a, pulse_b, id_b
  );

  modport slave (
    input  req_a,
    output pend_a, busy_a, ovf_a, done_a, pulse_b, id_b
  );
endinterface

// File: rtl/cdc_pulse_arbiter.sv
// Round-robin arbiter that shares one toggle/ack pulse crossing from the fast
// clka domain to the slow clkb domain among N_REQ requesters.
module cdc_pulse_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 rst,
  input  logic                 clka,
  input  logic                 clkb,
  cdc_pulse_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                 state, state_nxt;
  logic [N_REQ-1:0]       pend;
  logic [N_REQ-1:0]       clr;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        grant_idx;
  logic                   grant_vld;
  logic [ID_W:0]          scan;
  logic                   do_grant;
  logic                   done;
  logic                   busy;
  logic                   ovf;
  logic [ID_W-1:0]        id_a;
  logic                   req_tgl;
  logic [SYNC_STAGES-1:0] ack_meta;
  logic                   ack_sync;

  logic [SYNC_STAGES-1:0] req_meta;
  logic                   req_sync;
  logic                   req_prev;
  logic                   b_edge;
  logic                   ack_tgl;
  logic [N_REQ-1:0]       pulse;
  logic [N_REQ-1:0]       pulse_nxt;
  logic [ID_W-1:0]        id_b_q;

  assign ack_sync = ack_meta[SYNC_STAGES-1];
  assign req_sync = req_meta[SYNC_STAGES-1];
  assign b_edge   = req_sync ^ req_prev;

  // Rotating priority search: the first pending slot at or after rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(N_REQ))
        scan = scan - (ID_W+1)'(N_REQ);
      if (!grant_vld && pend[scan[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    clr       = '0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          do_grant       = 1'b1;
          clr[grant_idx] = 1'b1;
          state_nxt      = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (ack_sync == req_tgl) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A request landing on its own grant edge survives the clear and becomes a new event.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pend     <= '0;
      rr_ptr   <= '0;
      id_a     <= '0;
      req_tgl  <= 1'b0;
      ovf      <= 1'b0;
      ack_meta <= '0;
    end else begin
      state    <= state_nxt;
      pend     <= (pend & ~clr) | bus.req_a;
      ovf      <= |(bus.req_a & pend & ~clr);
      ack_meta <= {ack_meta[SYNC_STAGES-2:0], ack_tgl};
      if (do_grant) begin
        id_a    <= grant_idx;
        req_tgl <= ~req_tgl;
        rr_ptr  <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
    end
  end

  always_comb begin
    pulse_nxt       = '0;
    pulse_nxt[id_a] = 1'b1;
  end

  // id_a is held stable from grant until ack returns, so clkb samples it directly.
  always_ff @(posedge clkb or negedge rst) begin
    if (!rst) begin
      req_meta <= '0;
      req_prev <= 1'b0;
      ack_tgl  <= 1'b0;
      pulse    <= '0;
      id_b_q   <= '0;
    end else begin
      req_meta <= {req_meta[SYNC_STAGES-2:0], req_tgl};
      req_prev <= req_sync;
      pulse    <= '0;
      if (b_edge) begin
        pulse   <= pulse_nxt;
        id_b_q  <= id_a;
        ack_tgl <= req_sync;
      end
    end
  end

  assign bus.pend_a  = pend;
  assign bus.busy_a  = busy;
  assign bus.ovf_a   = ovf;
  assign bus.done_a  = done;
  assign bus.pulse_b = pulse;
  assign bus.id_b    = id_b_q;

  a_pulse_onehot: assert property (@(posedge clkb) disable iff (!rst) $onehot0(pulse));
  a_pulse_granted: assert property (@(posedge clkb) disable iff (!rst) b_edge |-> (state == WAIT));
  a_ack_once: assert property (@(posedge clka) disable iff (!rst)
    (ack_sync != $past(ack_sync)) |-> (state == WAIT && ack_sync == req_tgl));

endmodule

// File: tb/tb_cdc_pulse_arbiter.sv
// Scoreboard bench for cdc_pulse_arbiter: expected clkb pulses are queued as
// requests are driven and checked as the DUT delivers them.
module tb_cdc_pulse_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef struct {
    logic [N_REQ-1:0] pulse;
    logic [ID_W-1:0]  id;
  } exp_t;

  logic clka, clkb, rst;
  int   compared   = 0;
  int   mismatched = 0;
  int   done_cnt   = 0;
  int   ovf_cnt    = 0;
  exp_t exp_q[$];

  cdc_pulse_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  cdc_pulse_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .SYNC_STAGES(2)) dut (
    .rst  (rst),
    .clka (clka),
    .clkb (clkb),
    .bus  (bus)
  );

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  initial begin
    clkb = 1'b0;
    forever #20 clkb = ~clkb;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expectPulse(input int idx);
    exp_t e;
    e.pulse      = '0;
    e.pulse[idx] = 1'b1;
    e.id         = ID_W'(idx);
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] v);
    @(negedge clka);
    bus.req_a = v;
    @(negedge clka);
    bus.req_a = '0;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    repeat (3) @(negedge clka);
    rst = 1'b1;
    @(negedge clka);
  endtask

  task automatic waitQuiet(input string tag);
    int n = 0;
    while ((bus.busy_a || bus.pend_a != '0 || exp_q.size() != 0) && n < 2000) begin
      @(negedge clka);
      n++;
    end
    checkOutput({tag, "_quiet"}, 32'(n < 2000), 32'd1);
  endtask

  // Every delivered clkb pulse must match the head of the queue, one pop per clkb cycle.
  always @(negedge clkb) begin
    if (rst && bus.pulse_b != '0) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pulse", 32'(bus.pulse_b), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("pulse_b", 32'(bus.pulse_b), 32'(e.pulse));
        checkOutput("id_b", 32'(bus.id_b), 32'(e.id));
      end
    end
  end

  always @(negedge clka) begin
    if (rst) begin
      if (bus.done_a) done_cnt++;
      if (bus.ovf_a) ovf_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    bus.req_a = '0;
    repeat (3) @(negedge clka);
    checkOutput("rst_pend", 32'(bus.pend_a), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy_a), 32'd0);
    checkOutput("rst_ovf", 32'(bus.ovf_a), 32'd0);
    checkOutput("rst_done", 32'(bus.done_a), 32'd0);
    checkOutput("rst_pulse", 32'(bus.pulse_b), 32'd0);
    checkOutput("rst_id", 32'(bus.id_b), 32'd0);
    rst = 1'b1;
    @(negedge clka);

    $display("[TB] single request");
    done_cnt = 0;
    expectPulse(2);
    applyStimulus(4'b0100);
    checkOutput("t1_pend", 32'(bus.pend_a), 32'b0100);
    checkOutput("t1_idle", 32'(bus.busy_a), 32'd0);
    @(negedge clka);
    checkOutput("t1_pend_clr", 32'(bus.pend_a), 32'd0);
    checkOutput("t1_busy", 32'(bus.busy_a), 32'd1);
    waitQuiet("t1");
    checkOutput("t1_done", 32'(done_cnt), 32'd1);
    checkOutput("t1_busy_low", 32'(bus.busy_a), 32'd0);

    $display("[TB] simultaneous requests");
    applyReset();
    done_cnt = 0;
    ovf_cnt  = 0;
    for (int i = 0; i < N_REQ; i++) expectPulse(i);
    applyStimulus(4'b1111);
    checkOutput("t2_pend", 32'(bus.pend_a), 32'b1111);
    waitQuiet("t2");
    checkOutput("t2_done", 32'(done_cnt), 32'd4);
    checkOutput("t2_ovf", 32'(ovf_cnt), 32'd0);

    $display("[TB] round-robin fairness");
    expectPulse(2);
    expectPulse(0);
    expectPulse(2);
    applyStimulus(4'b0100);
    @(negedge clka);
    applyStimulus(4'b0101);
    checkOutput("t3_pend", 32'(bus.pend_a), 32'b0101);
    checkOutput("t3_busy", 32'(bus.busy_a), 32'd1);
    waitQuiet("t3");
    checkOutput("t3_ovf", 32'(ovf_cnt), 32'd0);

    $display("[TB] overflow");
    ovf_cnt = 0;
    expectPulse(0);
    expectPulse(1);
    applyStimulus(4'b0001);
    applyStimulus(4'b0010);
    checkOutput("t4_pend", 32'(bus.pend_a), 32'b0010);
    applyStimulus(4'b0010);
    checkOutput("t4_ovf_now", 32'(bus.ovf_a), 32'd1);
    checkOutput("t4_pend2", 32'(bus.pend_a), 32'b0010);
    waitQuiet("t4");
    checkOutput("t4_ovf_cnt", 32'(ovf_cnt), 32'd1);

    $display("[TB] same-cycle request and grant");
    ovf_cnt  = 0;
    done_cnt = 0;
    expectPulse(0);
    expectPulse(0);
    @(negedge clka);
    bus.req_a = 4'b0001;
    @(negedge clka);
    bus.req_a = 4'b0001;
    @(negedge clka);
    bus.req_a = '0;
    checkOutput("t5_busy", 32'(bus.busy_a), 32'd1);
    checkOutput("t5_pend", 32'(bus.pend_a), 32'b0001);
    checkOutput("t5_ovf_now", 32'(bus.ovf_a), 32'd0);
    waitQuiet("t5");
    checkOutput("t5_done", 32'(done_cnt), 32'd2);
    checkOutput("t5_ovf_cnt", 32'(ovf_cnt), 32'd0);

    $display("[TB] reset mid-flight");
    done_cnt = 0;
    applyStimulus(4'b0010);
    @(negedge clka);
    checkOutput("t6_busy", 32'(bus.busy_a), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t6_pend", 32'(bus.pend_a), 32'd0);
    checkOutput("t6_busy_rst", 32'(bus.busy_a), 32'd0);
    checkOutput("t6_ovf", 32'(bus.ovf_a), 32'd0);
    checkOutput("t6_done", 32'(bus.done_a), 32'd0);
    checkOutput("t6_pulse", 32'(bus.pulse_b), 32'd0);
    checkOutput("t6_id", 32'(bus.id_b), 32'd0);
    repeat (3) @(negedge clka);
    rst = 1'b1;
    repeat (100) @(negedge clkb);
    checkOutput("t6_busy_after", 32'(bus.busy_a), 32'd0);
    checkOutput("t6_done_cnt", 32'(done_cnt), 32'd0);
    checkOutput("final_queue", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cdc_pulse_arbiter.md
Name: cdc_pulse_arbiter

Overview:
- Shares one fast-to-slow pulse crossing between N_REQ requesters in the clka (fast) domain.
- Latches single-cycle request pulses and grants them round-robin, one at a time.
- Each grant is carried to the clkb (slow) domain as a toggle plus a quasi-static ID.
- The next grant waits for a synchronized acknowledge toggle from clkb, so no pulse is lost regardless of the clock ratio.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, 2, requester index width; must satisfy 2**ID_W >= N_REQ.
- SYNC_STAGES, 2, synchronizer flop count in each direction (>=2).

Ports:
- rst  input  1  reset, asynchronous, active-low; resets both domains.
- clka  input  1  fast clock.
- clkb  input  1  slow clock.
- req_a  input  N_REQ  single-cycle request pulses, clka domain.
- pend_a  output  N_REQ  pending-request flags, clka.
- busy_a  output  1  transfer in flight, clka.
- ovf_a  output  1  one-cycle pulse: a request hit an already-pending slot, clka.
- done_a  output  1  one-cycle pulse: acknowledge received, clka.
- pulse_b  output  N_REQ  one-hot one-clkb-cycle delivered pulse, clkb.
- id_b  output  ID_W  index of the last delivered pulse, clkb.

Behaviour:
- Reset values (rst low, async): pend_a=0, busy_a=0, ovf_a=0, done_a=0, pulse_b=0, id_b=0, all toggles and synchronizers 0, rr pointer=0, FSM=IDLE.
- Pending latch, per bit i, each clka edge:
  - pend[i] <= (pend[i] & ~clr[i]) | req_a[i].
  - clr[i] is the grant of slot i this cycle.
  - A request in the same cycle as its own grant leaves pend[i]=1, so it is a new event.
  - ovf_a=1 next cycle if any req_a[i] & pend[i] & ~clr[i]; the event merges and is not queued twice.
- Arbiter: round-robin over pend. Search starts at the rr pointer; on grant, the pointer becomes (granted index + 1) mod N_REQ.
- clka FSM:
  - IDLE: if pend != 0, register id_a <= granted index, flip req_tgl, clear pend[grant], go WAIT. Else stay.
  - WAIT: busy_a=1. When ack_sync == req_tgl, pulse done_a, go IDLE. The next grant is possible in that same IDLE cycle at the earliest, i.e. the cycle after done_a.
  - id_a and req_tgl change only at the grant edge. id_a stays stable until the acknowledge returns, which makes it safe to sample in clkb without synchronization.
- clkb side:
  - req_tgl passes through SYNC_STAGES flops plus one edge-detect flop.
  - On a detected edge: id_b <= id_a, pulse_b <= one-hot(id_a) for exactly one clkb cycle, ack_tgl <= synced req_tgl.
  - ack_tgl passes back to clka through SYNC_STAGES flops to form ack_sync.
- Latency:
  - req_a to pend_a: 1 clka.
  - pend to grant: 1 clka.
  - Grant to pulse_b: SYNC_STAGES+1 clkb edges (+1 for sampling uncertainty).
  - Delivery to done_a: SYNC_STAGES+1 clka.
- Throughput: one delivery per round trip; requests arriving meanwhile accumulate in pend_a.
- Any clka:clkb ratio is legal, including clkb faster than clka.
- Reset mid-transfer clears both domains. The pulse in flight is either delivered before reset or dropped; no spurious pulse_b after reset release.
- Assertions:
  - pulse_b is one-hot or zero.
  - No pulse_b without a preceding grant.
  - ack_sync toggles once per grant.

Test Plan:
- Single request: clka 100 MHz, clkb 25 MHz, SYNC_STAGES=2, req_a=4'b0100 for one cycle → pend_a[2]=1 for 1 clka cycle, busy_a high, exactly one pulse_b=4'b0100 of one clkb cycle with id_b=2, then done_a one pulse and busy_a low.
- Simultaneous requests: req_a=4'b1111 in one cycle → pulse_b delivered in order 0001, 0010, 0100, 1000; one pulse each; done_a asserted 4 times.
- Round-robin fairness: after slot 2 is granted, requests 4'b0101 pending → slot 0 next (pointer at 3 wraps), then slot 2.
- Overflow: req_a[1] pulses twice while slot 1 is pending and not granted → ovf_a one pulse on the second request, only one pulse_b=4'b0010 delivered.
- Same-cycle request and grant: req_a[0] asserted in the grant cycle of slot 0 → pend_a[0] stays 1, two pulse_b=4'b0001 deliveries, ovf_a=0.
- Reset mid-flight: assert rst low while busy_a=1 → all outputs 0 immediately. After release with no requests, no pulse_b for 100 clkb cycles.
